// File: rtl/fetch_if.sv
// Instruction-memory bus and decode-register outputs of the fetch stage.
// The fetch stage uses the master modport; memory and decode use the slave modport.
interface fetch_if;
    logic        imem_req_out;
    logic [63:0] imem_addr_out;
    logic        imem_ready_in;
    logic [63:0] imem_rdata_in;
    logic        valid_out;
    logic [63:0] pc_out;
    logic [63:0] instr_out;
    logic        branch_predicted_taken_out;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_ready_in, imem_rdata_in,
        output valid_out, pc_out, instr_out, branch_predicted_taken_out
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_ready_in, imem_rdata_in,
        input  valid_out, pc_out, instr_out, branch_predicted_taken_out
    );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request per cycle and predicts
// the next PC from a direct-mapped BTB with 2-bit counters trained by execute.
module fetch #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [63:0] redirect_pc_in,
    input  logic        bp_update_in,
    input  logic [63:0] bp_update_pc_in,
    input  logic        bp_update_taken_in,
    input  logic [63:0] bp_update_target_in,
    fetch_if.master     bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 64 - 3 - IDX;

    logic [63:0] pc_q, pc_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [63:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        pred_q, pred_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [63:0]            btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, lk_taken;
    logic [63:0]      next_pc;
    logic             up_hit, up_we;
    logic [1:0]       up_ctr;
    logic [63:0]      up_target;
    logic             unused_low_bits;

    assign unused_low_bits = ^bp_update_pc_in[2:0];

    // Lookup reads the pre-update BTB state; a same-cycle update is not bypassed.
    always_comb begin
        lk_idx   = pc_q[3 +: IDX];
        lk_tag   = pc_q[63:3+IDX];
        lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && btb_ctr_q[lk_idx][1];
        next_pc  = lk_taken ? btb_target_q[lk_idx] : pc_q + 64'd8;
    end

    always_comb begin
        up_idx    = bp_update_pc_in[3 +: IDX];
        up_tag    = bp_update_pc_in[63:3+IDX];
        up_hit    = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
        up_we     = 1'b0;
        up_ctr    = btb_ctr_q[up_idx];
        up_target = btb_target_q[up_idx];
        if (bp_update_in) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (bp_update_taken_in) begin
                    up_ctr    = (btb_ctr_q[up_idx] == 2'b11) ? 2'b11 : btb_ctr_q[up_idx] + 2'd1;
                    up_target = bp_update_target_in;
                end else begin
                    up_ctr = (btb_ctr_q[up_idx] == 2'b00) ? 2'b00 : btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (bp_update_taken_in) begin
                up_we     = 1'b1;
                up_ctr    = 2'b10;
                up_target = bp_update_target_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid_q <= '0;
        end else if (up_we) begin
            btb_valid_q[up_idx] <= 1'b1;
        end
    end

    // Tags, targets and counters are only observed behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (up_we) begin
            btb_tag_q[up_idx]    <= up_tag;
            btb_target_q[up_idx] <= up_target;
            btb_ctr_q[up_idx]    <= up_ctr;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pred_d   = pred_q;
        if (redirect_in) begin
            pc_d    = redirect_pc_in;
            valid_d = 1'b0;
        end else if (stall_in) begin
            pc_d = pc_q;
        end else if (bus.imem_ready_in) begin
            instr_d  = bus.imem_rdata_in;
            out_pc_d = pc_q;
            pred_d   = lk_taken;
            valid_d  = 1'b1;
            pc_d     = next_pc;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            out_pc_q <= 64'h0;
            instr_q  <= 64'h0;
            valid_q  <= 1'b0;
            pred_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pred_q   <= pred_d;
        end
    end

    assign bus.imem_req_out               = !reset && !stall_in && !redirect_in;
    assign bus.imem_addr_out              = pc_q;
    assign bus.valid_out                  = valid_q;
    assign bus.pc_out                     = out_pc_q;
    assign bus.instr_out                  = instr_q;
    assign bus.branch_predicted_taken_out = pred_q;
endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: sequencing, stalls, memory waits, redirects,
// BTB training and address wrap, with hand-computed expectations.
module tb_fetch;
    localparam logic [63:0] XM = 64'hDEAD_BEEF_0000_0000;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [63:0] redirect_pc_in;
    logic        bp_update_in;
    logic [63:0] bp_update_pc_in;
    logic        bp_update_taken_in;
    logic [63:0] bp_update_target_in;
    int          nvec;
    int          nerr;

    fetch_if bus ();

    // Instruction memory returns a word derived from its address.
    assign bus.imem_rdata_in = bus.imem_addr_out ^ XM;

    fetch #(.RESET_PC(64'h1000), .BTB_ENTRIES(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_in            (stall_in),
        .redirect_in         (redirect_in),
        .redirect_pc_in      (redirect_pc_in),
        .bp_update_in        (bp_update_in),
        .bp_update_pc_in     (bp_update_pc_in),
        .bp_update_taken_in  (bp_update_taken_in),
        .bp_update_target_in (bp_update_target_in),
        .bus                 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] pc, input logic p,
                           input logic [63:0] addr);
        chk({tag, "_valid"}, {63'h0, bus.valid_out}, {63'h0, v});
        if (v) begin
            chk({tag, "_pc"}, bus.pc_out, pc);
            chk({tag, "_instr"}, bus.instr_out, pc ^ XM);
            chk({tag, "_pred"}, {63'h0, bus.branch_predicted_taken_out}, {63'h0, p});
        end
        chk({tag, "_addr"}, bus.imem_addr_out, addr);
    endtask

    task automatic redirect_to(input logic [63:0] target);
        redirect_in    = 1'b1;
        redirect_pc_in = target;
        tick();
        chk("redir_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("redir_addr", bus.imem_addr_out, target);
        redirect_in = 1'b0;
    endtask

    initial begin
        nvec                = 0;
        nerr                = 0;
        reset               = 1'b1;
        stall_in            = 1'b0;
        redirect_in         = 1'b0;
        redirect_pc_in      = 64'h0;
        bp_update_in        = 1'b0;
        bp_update_pc_in     = 64'h0;
        bp_update_taken_in  = 1'b0;
        bp_update_target_in = 64'h0;
        bus.imem_ready_in   = 1'b1;

        tick();
        chk("rst_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("rst_pc_out", bus.pc_out, 64'h0);
        chk("rst_instr", bus.instr_out, 64'h0);
        chk("rst_pred", {63'h0, bus.branch_predicted_taken_out}, 64'h0);
        chk("rst_req", {63'h0, bus.imem_req_out}, 64'h0);
        chk("rst_addr", bus.imem_addr_out, 64'h1000);

        reset = 1'b0;
        #1;
        chk("first_req", {63'h0, bus.imem_req_out}, 64'h1);
        tick();
        chk_out("seq0", 1'b1, 64'h1000, 1'b0, 64'h1008);

        // Memory wait for two cycles at 0x1008.
        bus.imem_ready_in = 1'b0;
        tick();
        chk_out("wait0", 1'b0, 64'h0, 1'b0, 64'h1008);
        tick();
        chk_out("wait1", 1'b0, 64'h0, 1'b0, 64'h1008);
        bus.imem_ready_in = 1'b1;
        tick();
        chk_out("seq1", 1'b1, 64'h1008, 1'b0, 64'h1010);

        // Stall for three cycles: everything frozen.
        stall_in = 1'b1;
        #1;
        chk("stall_req", {63'h0, bus.imem_req_out}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 64'h1008, 1'b0, 64'h1010);
        end
        stall_in = 1'b0;
        tick();
        chk_out("seq2", 1'b1, 64'h1010, 1'b0, 64'h1018);

        // Train 0x1010 taken -> 0x2000 (ctr=10).
        bp_update_in        = 1'b1;
        bp_update_pc_in     = 64'h1010;
        bp_update_taken_in  = 1'b1;
        bp_update_target_in = 64'h2000;
        tick();
        chk_out("seq3", 1'b1, 64'h1018, 1'b0, 64'h1020);
        bp_update_in = 1'b0;

        redirect_to(64'h1010);
        tick();
        chk_out("bt_taken", 1'b1, 64'h1010, 1'b1, 64'h2000);
        tick();
        chk_out("bt_target", 1'b1, 64'h2000, 1'b0, 64'h2008);

        // Two not-taken updates: ctr 10 -> 01 -> 00.
        bp_update_in       = 1'b1;
        bp_update_taken_in = 1'b0;
        tick();
        tick();
        chk_out("nt_seq", 1'b1, 64'h2010, 1'b0, 64'h2018);
        bp_update_in = 1'b0;

        redirect_to(64'h1010);
        tick();
        chk_out("bt_nt", 1'b1, 64'h1010, 1'b0, 64'h1018);

        // One taken update: ctr 00 -> 01, still predicts not taken.
        bp_update_in       = 1'b1;
        bp_update_taken_in = 1'b1;
        tick();
        bp_update_in = 1'b0;
        redirect_to(64'h1010);

        // Same-cycle update (01 -> 10) and lookup: prediction uses old counter.
        bp_update_in = 1'b1;
        tick();
        chk_out("same_cyc", 1'b1, 64'h1010, 1'b0, 64'h1018);
        bp_update_in = 1'b0;
        redirect_to(64'h1010);
        tick();
        chk_out("after_upd", 1'b1, 64'h1010, 1'b1, 64'h2000);

        // Redirect coincident with ready and stall: data dropped.
        redirect_in       = 1'b1;
        redirect_pc_in    = 64'h3000;
        stall_in          = 1'b1;
        bus.imem_ready_in = 1'b1;
        #1;
        chk("rd_req", {63'h0, bus.imem_req_out}, 64'h0);
        tick();
        chk_out("rd_drop", 1'b0, 64'h0, 1'b0, 64'h3000);
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        #1;
        chk("rd_req2", {63'h0, bus.imem_req_out}, 64'h1);
        tick();
        chk_out("rd_deliver", 1'b1, 64'h3000, 1'b0, 64'h3008);

        // Sequential PC wraps modulo 2^64.
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        chk_out("wrap0", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0);
        tick();
        chk_out("wrap1", 1'b1, 64'h0, 1'b0, 64'h8);

        // Asynchronous reset mid-operation.
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {63'h0, bus.valid_out}, 64'h0);
        chk("mid_rst_pc_out", bus.pc_out, 64'h0);
        chk("mid_rst_addr", bus.imem_addr_out, 64'h1000);
        reset = 1'b0;
        tick();
        chk_out("post_rst", 1'b1, 64'h1000, 1'b0, 64'h1008);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the five-stage 64-bit core: owns the program counter, issues one 64-bit instruction-memory request per cycle, and delivers `pc_out`/`instr_out`/`branch_predicted_taken_out` into the decode stage's `pc_in`/`instr_in`/`branch_predicted_taken_in` registers. It predicts the next PC with a small direct-mapped branch target buffer (BTB) and 2-bit counters, trained from execute. It accepts redirects from execute on misprediction.

## Interface
- `RESET_PC`, 64'h0: first fetch address after reset; must be 8-byte aligned.
- `BTB_ENTRIES`, 16: BTB depth; power of two, ≥2. `IDX = log2(BTB_ENTRIES)`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall_in`  in  1  hazard-unit stall (same signal that stalls decode).
- `redirect_in`  in  1  execute-stage redirect (mispredict or jump).
- `redirect_pc_in`  in  64  redirect target; 8-byte aligned.
- `bp_update_in`  in  1  train BTB with a resolved branch this cycle.
- `bp_update_pc_in`  in  64  PC of resolved branch.
- `bp_update_taken_in`  in  1  resolved direction.
- `bp_update_target_in`  in  64  resolved taken target.
- `imem_req_out`  out  1  fetch request.
- `imem_addr_out`  out  64  fetch address (= PC register).
- `imem_ready_in`  in  1  request accepted; `imem_rdata_in` valid this cycle.
- `imem_rdata_in`  in  64  instruction word.
- `valid_out`  out  1  registered: decode inputs carry a real instruction. Hazard unit ORs `!valid_out` into decode's `flush_in`.
- `pc_out`  out  64  registered PC of `instr_out`.
- `instr_out`  out  64  registered instruction word.
- `branch_predicted_taken_out`  out  1  registered prediction used for this instruction.

## Operation
- Instructions are 64 bits; sequential next PC = PC + 8 (wraps modulo 2^64).
- `imem_req_out = !reset && !stall_in && !redirect_in`; `imem_addr_out` = PC register, stable while request is outstanding.
- BTB entry: `valid`, `tag = pc[63:3+IDX]`, `target[63:0]`, `ctr[1:0]`. Index = `pc[3+IDX-1:3]`.
- Lookup (combinational on PC register): hit = valid && tag match. Predict taken iff hit && `ctr[1]`. Next PC = taken ? target : PC + 8.
- Update on `bp_update_in`, using entry indexed by `bp_update_pc_in`:
  - hit: `ctr` saturating increment if taken, else saturating decrement (floor 00, ceiling 11); target overwritten when taken.
  - miss and taken: allocate/replace: valid=1, new tag, target, `ctr=2'b10`.
  - miss and not taken: no change.
- Lookup and update in the same cycle: lookup sees pre-update state (no bypass).
- Per-edge priority:
  1. `redirect_in`: PC ← `redirect_pc_in`; `valid_out` ← 0. This applies even when `stall_in` is high. Any same-cycle `imem_ready_in` data is discarded.
  2. else `stall_in`: all output registers and PC hold.
  3. else `imem_ready_in`: `instr_out` ← `imem_rdata_in`, `pc_out` ← PC, `branch_predicted_taken_out` ← prediction, `valid_out` ← 1, PC ← next PC.
  4. else (memory wait): `valid_out` ← 0; PC, `pc_out`, `instr_out` and `branch_predicted_taken_out` hold.
- BTB updates proceed regardless of stall/redirect.

## Timing
- Reset (asynchronous assertion, synchronous-safe release):
  - PC = `RESET_PC`, `valid_out` = 0, `pc_out` = 0, `instr_out` = 0, `branch_predicted_taken_out` = 0.
  - All BTB valid bits = 0. Tags, targets and counters are unreset and unobservable until written.
- Reset mid-operation: outputs go to reset values immediately. The first request after deassertion is to `RESET_PC`.
- Latency: address presented in cycle N with ready → instruction on outputs from cycle N+1.
- Throughput: one instruction per cycle with `imem_ready_in` held high.
- Predicted-taken branch: target fetched in the cycle immediately after the branch, with no bubble.
- Redirect in cycle N: `valid_out` = 0 in N+1; `redirect_pc_in` is requested in N+1; its instruction is valid in N+2.

## Test plan
- Reset, `RESET_PC`=0x1000, ready always 1 → requests 0x1000, 0x1008, 0x1010; `pc_out` follows one cycle later with `valid_out`=1.
- Ready low 2 cycles at 0x1008 → `imem_addr_out` holds 0x1008; `valid_out`=0 for those cycles; then 0x1008 is delivered.
- `stall_in` high 3 cycles → `imem_req_out`=0, all outputs and PC frozen; resumes with no lost or duplicated instruction.
- Train PC 0x1010 taken→0x2000 once (ctr=10) → next fetch of 0x1010 gives `branch_predicted_taken_out`=1 and the next request is 0x2000. Train not-taken twice → ctr=00; next fetch predicts not taken, next request 0x1018.
- `redirect_in` to 0x3000 coincident with `imem_ready_in` and `stall_in` → data dropped, `valid_out`=0 next cycle, then 0x3000 is requested.
- Update and lookup of the same index in one cycle → the prediction reflects the old counter; the new counter is visible on the next lookup. 0xFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.
